// File: rtl/dct_it_math.sv
// Inverse 8-point lifting binDCT: seven registered stages, one vector per cycle.
// The forward lifting steps are undone in reverse order with identical rounding.
module dct_it_math #(
   parameter int W_I   = 16,
   parameter int W_O   = 16,
   parameter int W_INT = W_I + 4
) (
   input  logic               clk_i,
   input  logic               rst_n,
   input  logic               in_valid_i,
   input  logic [8*W_I-1:0]   in_data_i,
   output logic               out_valid_o,
   output logic [8*W_O-1:0]   out_data_o
);

   typedef logic signed [W_INT-1:0] lane_t;

   localparam lane_t OMax = lane_t'((2 ** (W_O - 1)) - 1);
   localparam lane_t OMin = lane_t'(-(2 ** (W_O - 1)));

   // Round-half-away-from-zero of k*v/8.
   function automatic lane_t rnd(input logic [2:0] k, input lane_t v);
      logic signed [W_INT+3:0] ve, ke, p, m;
      ve = {{4{v[W_INT-1]}}, v};
      ke = {{(W_INT + 1){1'b0}}, k};
      p  = ve * ke;
      m  = p[W_INT+3] ? -p : p;
      m  = (m + (W_INT + 4)'(4)) >>> 3;
      return p[W_INT+3] ? -m[W_INT-1:0] : m[W_INT-1:0];
   endfunction

   // Floor of (a +/- b)/2, computed one bit wider so the sum cannot wrap.
   function automatic lane_t half(input lane_t a, input lane_t b, input logic sub);
      logic signed [W_INT:0] s;
      s = sub ? ({a[W_INT-1], a} - {b[W_INT-1], b}) : ({a[W_INT-1], a} + {b[W_INT-1], b});
      return s[W_INT:1];
   endfunction

   function automatic logic [W_O-1:0] sat(input lane_t v);
      if (v > OMax) return OMax[W_O-1:0];
      if (v < OMin) return OMin[W_O-1:0];
      return v[W_O-1:0];
   endfunction

   logic [6:0] vld_q;
   lane_t      s1_d [8], s1_q [8];
   lane_t      s2_d [8], s2_q [8];
   lane_t      s3_d [8], s3_q [8];
   lane_t      s4_d [8], s4_q [8];
   lane_t      s5_d [8], s5_q [8];
   lane_t      s6_d [8], s6_q [8];
   lane_t      x [8];
   logic [8*W_O-1:0] out_d, out_q;

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         s1_d[i] = lane_t'($signed(in_data_i[i*W_I +: W_I]));
      end

      // Lanes: y0 c1 y2 c3 c4 y5 c6 y7
      s2_d    = s1_q;
      s2_d[1] = rnd(3'd4, s1_q[0]) - s1_q[1];
      s2_d[3] = s1_q[3] - rnd(3'd3, s1_q[2]);
      s2_d[4] = s1_q[4] + rnd(3'd1, s1_q[7]);
      s2_d[6] = s1_q[6] + rnd(3'd4, s1_q[5]);

      s3_d    = s2_q;
      s3_d[0] = s2_q[0] - s2_q[1];
      s3_d[2] = s2_q[2] + rnd(3'd3, s2_q[3]);
      s3_d[5] = s2_q[5] - rnd(3'd7, s2_q[6]);

      // Lanes: a0 a1 a2 a3 a4 b5 b6 a7
      s4_d[0] = half(s3_q[0], s3_q[3], 1'b0);
      s4_d[3] = half(s3_q[0], s3_q[3], 1'b1);
      s4_d[1] = half(s3_q[1], s3_q[2], 1'b0);
      s4_d[2] = half(s3_q[1], s3_q[2], 1'b1);
      s4_d[4] = half(s3_q[4], s3_q[5], 1'b0);
      s4_d[5] = half(s3_q[4], s3_q[5], 1'b1);
      s4_d[7] = half(s3_q[7], s3_q[6], 1'b0);
      s4_d[6] = half(s3_q[7], s3_q[6], 1'b1);

      s5_d    = s4_q;
      s5_d[5] = rnd(3'd5, s4_q[6]) - s4_q[5];

      s6_d    = s5_q;
      s6_d[6] = s5_q[6] - rnd(3'd3, s5_q[5]);

      x[0] = half(s6_q[0], s6_q[7], 1'b0);
      x[7] = half(s6_q[0], s6_q[7], 1'b1);
      x[1] = half(s6_q[1], s6_q[6], 1'b0);
      x[6] = half(s6_q[1], s6_q[6], 1'b1);
      x[2] = half(s6_q[2], s6_q[5], 1'b0);
      x[5] = half(s6_q[2], s6_q[5], 1'b1);
      x[3] = half(s6_q[3], s6_q[4], 1'b0);
      x[4] = half(s6_q[3], s6_q[4], 1'b1);

      out_d = '0;
      for (int i = 0; i < 8; i++) begin
         out_d[i*W_O +: W_O] = sat(x[i]);
      end
   end

   // Each stage loads only behind a valid vector so bubbles leave data untouched.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         out_q <= '0;
         for (int i = 0; i < 8; i++) begin
            s1_q[i] <= '0;
            s2_q[i] <= '0;
            s3_q[i] <= '0;
            s4_q[i] <= '0;
            s5_q[i] <= '0;
            s6_q[i] <= '0;
         end
      end else begin
         vld_q <= {vld_q[5:0], in_valid_i};
         if (in_valid_i) s1_q <= s1_d;
         if (vld_q[0])   s2_q <= s2_d;
         if (vld_q[1])   s3_q <= s3_d;
         if (vld_q[2])   s4_q <= s4_d;
         if (vld_q[3])   s5_q <= s5_d;
         if (vld_q[4])   s6_q <= s6_d;
         if (vld_q[5])   out_q <= out_d;
      end
   end

   assign out_valid_o = vld_q[6];
   assign out_data_o  = out_q;

endmodule

// File: tb/tb_dct_it_math.sv
// Bench for dct_it_math: integer reference of the inverse transform plus a forward
// transform for round trips; two instances cover 16-bit and 8-bit saturation.
module tb_dct_it_math;

   typedef int vec_t [8];
   localparam int NCYC = 4096;

   logic         clk_i = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid_i = 1'b0;
   logic [127:0] in_data_i = '0;
   logic         out_valid16, out_valid8;
   logic [127:0] out_data16;
   logic [63:0]  out_data8;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   bit   exp_v [NCYC];
   vec_t exp_x [NCYC];
   vec_t held;

   dct_it_math #(.W_I(16), .W_O(16)) dut16 (
      .clk_i(clk_i), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
      .out_valid_o(out_valid16), .out_data_o(out_data16)
   );

   dct_it_math #(.W_I(16), .W_O(8)) dut8 (
      .clk_i(clk_i), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
      .out_valid_o(out_valid8), .out_data_o(out_data8)
   );

   always #5 clk_i = ~clk_i;

   function automatic int rr(input int v);
      if (v >= 0) return (v + 4) / 8;
      return -((-v + 4) / 8);
   endfunction

   function automatic void inv(input vec_t y, output vec_t x);
      int c0, c1, c2, c3, c4, c5, c6, c7, a0, a1, a2, a3, a4, a5, a6, a7, b5, b6;
      c1 = rr(4 * y[0]) - y[1];
      c3 = y[3] - rr(3 * y[2]);
      c4 = y[4] + rr(y[7]);
      c6 = y[6] + rr(4 * y[5]);
      c0 = y[0] - c1;
      c2 = y[2] + rr(3 * c3);
      c5 = y[5] - rr(7 * c6);
      c7 = y[7];
      a0 = (c0 + c3) >>> 1;  a3 = (c0 - c3) >>> 1;
      a1 = (c1 + c2) >>> 1;  a2 = (c1 - c2) >>> 1;
      a4 = (c4 + c5) >>> 1;  b5 = (c4 - c5) >>> 1;
      a7 = (c7 + c6) >>> 1;  b6 = (c7 - c6) >>> 1;
      a5 = rr(5 * b6) - b5;
      a6 = b6 - rr(3 * a5);
      x[0] = (a0 + a7) >>> 1;  x[7] = (a0 - a7) >>> 1;
      x[1] = (a1 + a6) >>> 1;  x[6] = (a1 - a6) >>> 1;
      x[2] = (a2 + a5) >>> 1;  x[5] = (a2 - a5) >>> 1;
      x[3] = (a3 + a4) >>> 1;  x[4] = (a3 - a4) >>> 1;
   endfunction

   function automatic void fwd(input vec_t x, output vec_t y);
      int a0, a1, a2, a3, a4, a5, a6, a7, b5, b6, c0, c1, c2, c3, c4, c5, c6, c7;
      a0 = x[0] + x[7];  a7 = x[0] - x[7];
      a1 = x[1] + x[6];  a6 = x[1] - x[6];
      a2 = x[2] + x[5];  a5 = x[2] - x[5];
      a3 = x[3] + x[4];  a4 = x[3] - x[4];
      b6 = a6 + rr(3 * a5);
      b5 = rr(5 * b6) - a5;
      c7 = a7 + b6;  c6 = a7 - b6;
      c4 = a4 + b5;  c5 = a4 - b5;
      c0 = a0 + a3;  c3 = a0 - a3;
      c1 = a1 + a2;  c2 = a1 - a2;
      y[7] = c7;
      y[5] = c5 + rr(7 * c6);
      y[2] = c2 - rr(3 * c3);
      y[0] = c0 + c1;
      y[1] = rr(4 * y[0]) - c1;
      y[3] = c3 + rr(3 * y[2]);
      y[4] = c4 - rr(y[7]);
      y[6] = c6 - rr(4 * y[5]);
   endfunction

   function automatic int sat(input int v, input int w);
      int hi, lo;
      hi = (1 << (w - 1)) - 1;
      lo = -(1 << (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic logic [255:0] pack32(input vec_t v);
      logic [255:0] p;
      for (int i = 0; i < 8; i++) p[i*32 +: 32] = v[i];
      return p;
   endfunction

   function automatic logic [255:0] pack_sat(input vec_t v, input int w);
      logic [255:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) begin
         if (w == 16) p[i*16 +: 16] = 16'(sat(v[i], 16));
         else         p[i*8 +: 8]   = 8'(sat(v[i], 8));
      end
      return p;
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
      end
   endtask

   // Schedule the model result for every vector the DUT accepts.
   always @(posedge clk_i) begin
      vec_t yy, xx;
      if (rst_n && in_valid_i && (cyc + 6 < NCYC)) begin
         for (int i = 0; i < 8; i++) yy[i] = int'($signed(in_data_i[i*16 +: 16]));
         inv(yy, xx);
         exp_v[cyc + 6] = 1'b1;
         exp_x[cyc + 6] = xx;
      end
      cyc = cyc + 1;
   end

   always @(negedge rst_n) begin
      for (int i = 0; i < NCYC; i++) exp_v[i] = 1'b0;
      for (int i = 0; i < 8; i++) held[i] = 0;
   end

   always @(negedge clk_i) begin
      int idx;
      if (!rst_n) begin
         chk("rst_valid16", 256'(out_valid16), 256'(0));
         chk("rst_data16", 256'(out_data16), 256'(0));
         chk("rst_valid8", 256'(out_valid8), 256'(0));
         chk("rst_data8", 256'(out_data8), 256'(0));
      end else if (cyc > 0 && cyc <= NCYC) begin
         idx = cyc - 1;
         if (exp_v[idx]) held = exp_x[idx];
         chk("valid16", 256'(out_valid16), 256'(exp_v[idx]));
         chk("valid8", 256'(out_valid8), 256'(exp_v[idx]));
         chk("data16", 256'(out_data16), pack_sat(held, 16));
         chk("data8", 256'(out_data8), pack_sat(held, 8));
      end
   end

   task automatic drive(input vec_t y, input bit v);
      @(negedge clk_i);
      in_valid_i = v;
      for (int i = 0; i < 8; i++) in_data_i[i*16 +: 16] = 16'(y[i]);
   endtask

   task automatic rand_vec(output vec_t v);
      for (int i = 0; i < 8; i++) v[i] = int'($urandom_range(255)) - 128;
   endtask

   task automatic idle(input int n);
      vec_t g;
      for (int k = 0; k < n; k++) begin
         rand_vec(g);
         drive(g, 1'b0);
      end
   endtask

   task automatic pin_inv(input string name, input vec_t y, input vec_t x_req);
      vec_t x;
      inv(y, x);
      chk(name, pack32(x), pack32(x_req));
   endtask

   initial begin
      vec_t y, x, r;
      vec_t y_dc   = '{2040, 0, 0, 0, 0, 0, 0, 0};
      vec_t y_ndc  = '{-2040, 0, 0, 0, 0, 0, 0, 0};
      vec_t y_rt   = '{10, 5, -4, 8, -1, 9, 5, 10};
      vec_t x_rt   = '{10, 0, 0, 0, 0, 0, 0, 0};
      vec_t y_nh   = '{0, 0, 0, -4, 0, 0, 0, 0};
      vec_t y_ph   = '{0, 0, 0, 4, 0, 0, 0, 0};
      vec_t y_max  = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
      vec_t y_min  = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
      vec_t y_alt  = '{32767, -32768, 32767, -32768, 32767, -32768, 32767, -32768};
      vec_t y_alt2 = '{-32768, 32767, -32768, 32767, -32768, 32767, -32768, 32767};
      int   pat [6] = '{1, 0, 0, 1, 0, 1};

      // Hand-computed anchors for the reference itself.
      pin_inv("model_dc", y_dc, '{255, 255, 255, 255, 255, 255, 255, 255});
      pin_inv("model_rt", y_rt, x_rt);
      pin_inv("model_neg_half", y_nh, '{-1, -1, 0, 1, 1, 0, -1, -1});
      pin_inv("model_pos_half", y_ph, '{1, 0, -1, -1, -1, -1, 0, 1});
      fwd(x_rt, r);
      chk("model_fwd", pack32(r), pack32(y_rt));
      inv(y_dc, r);
      chk("model_sat8_hi", pack_sat(r, 8), 256'({8{8'd127}}));
      inv(y_ndc, r);
      chk("model_sat8_lo", pack_sat(r, 8), 256'({8{8'h80}}));

      repeat (3) @(negedge clk_i);
      #2 rst_n = 1'b1;

      idle(3);
      drive(y_dc, 1'b1);
      idle(9);
      drive(y_rt, 1'b1);
      drive(y_nh, 1'b1);
      drive(y_ph, 1'b1);
      drive(y_ndc, 1'b1);
      drive(y_max, 1'b1);
      drive(y_min, 1'b1);
      drive(y_alt, 1'b1);
      drive(y_alt2, 1'b1);
      idle(9);

      // Back-to-back stream, then a gapped valid pattern.
      for (int k = 0; k < 20; k++) begin
         rand_vec(x);
         fwd(x, y);
         drive(y, 1'b1);
      end
      for (int k = 0; k < 6; k++) begin
         rand_vec(x);
         fwd(x, y);
         drive(y, pat[k] != 0);
      end
      idle(10);

      // Random round trips with random bubbles.
      for (int k = 0; k < 300; k++) begin
         rand_vec(x);
         fwd(x, y);
         inv(y, r);
         chk("roundtrip_model", pack32(r), pack32(x));
         drive(y, $urandom_range(3) != 0);
      end
      idle(9);

      // Reset in the middle of a full stream.
      for (int k = 0; k < 10; k++) begin
         rand_vec(x);
         fwd(x, y);
         drive(y, 1'b1);
      end
      @(negedge clk_i);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid16", 256'(out_valid16), 256'(0));
      chk("async_rst_data16", 256'(out_data16), 256'(0));
      chk("async_rst_valid8", 256'(out_valid8), 256'(0));
      chk("async_rst_data8", 256'(out_data8), 256'(0));
      repeat (2) @(negedge clk_i);
      in_valid_i = 1'b0;
      #2 rst_n = 1'b1;
      idle(5);
      drive(y_rt, 1'b1);
      idle(12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
